// File: rtl/ebpc_pkg.sv
// Shared EBPC decoder definitions.
package ebpc_pkg;

    // Width of the per-block word-count field.
    localparam int unsigned LOG_MAX_WORDS = 8;

    // ZNZ expander control states.
    typedef enum logic {IDLE, RUN} znz_exp_state_t;

endpackage

// File: rtl/ebpc_mask_buf.sv
// Single-beat zero/non-zero mask buffer with a bit pointer.
// Holds one mask beat and presents the bit of the word being stepped.
module ebpc_mask_buf #(
    parameter int unsigned MASK_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [MASK_W-1:0] mask_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              flush_i,
    output logic              cur_bit_o,
    output logic              vld_o
);

    localparam int unsigned PtrW = (MASK_W > 1) ? $clog2(MASK_W) : 1;

    logic [MASK_W-1:0] mask_q, mask_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic              vld_q, vld_d;

    assign cur_bit_o = mask_q[ptr_q];
    assign vld_o     = vld_q;

    // Load a fresh beat, or advance the pointer; empty on the last bit or on block end.
    always_comb begin
        mask_d = mask_q;
        ptr_d  = ptr_q;
        vld_d  = vld_q;
        if (load_i) begin
            mask_d = mask_i;
            ptr_d  = '0;
            vld_d  = 1'b1;
        end else if (step_i) begin
            if (flush_i || (ptr_q == PtrW'(MASK_W - 1))) begin
                // Unused high bits of the beat are discarded here.
                ptr_d = '0;
                vld_d = 1'b0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    // Buffer state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q <= '0;
            ptr_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: rtl/ebpc_znz_expander.sv
// EBPC ZNZ expander: merges a zero/non-zero mask stream and a non-zero
// value stream into dense multi-lane beats framed by a per-block word count.
module ebpc_znz_expander
    import ebpc_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned LANES         = 4,
    parameter int unsigned MASK_W        = 8,
    parameter int unsigned LOG_MAX_WORDS = ebpc_pkg::LOG_MAX_WORDS
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [LOG_MAX_WORDS-1:0] num_words_i,
    input  logic                     num_words_vld_i,
    output logic                     num_words_rdy_o,
    input  logic [MASK_W-1:0]        mask_i,
    input  logic                     mask_vld_i,
    output logic                     mask_rdy_o,
    input  logic [DATA_W-1:0]        nz_i,
    input  logic                     nz_vld_i,
    output logic                     nz_rdy_o,
    output logic [LANES*DATA_W-1:0]  data_o,
    output logic [LANES-1:0]         strb_o,
    output logic                     last_o,
    output logic                     vld_o,
    input  logic                     rdy_i,
    output logic                     idle_o
);

    localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned BeatW = LANES * DATA_W;

    znz_exp_state_t           state_q, state_d;
    logic [LOG_MAX_WORDS-1:0] remaining_q, remaining_d;
    logic [LaneW-1:0]         lane_idx_q, lane_idx_d;
    logic [BeatW-1:0]         asm_q, asm_d;
    logic [BeatW-1:0]         out_data_q, out_data_d;
    logic [LANES-1:0]         out_strb_q, out_strb_d;
    logic                     out_last_q, out_last_d;
    logic                     out_vld_q, out_vld_d;

    logic                     buf_vld;
    logic                     cur_bit;
    logic                     mask_load;
    logic                     running;
    logic                     final_word;
    logic                     completing;
    logic                     out_free;
    logic                     step;
    logic [DATA_W-1:0]        word;
    logic [BeatW-1:0]         asm_wr;
    logic [LANES-1:0]         strb_wr;

    // Handshake outputs are gated by reset so nothing transfers while it is held.
    assign running    = (state_q == RUN) && !rst_i;
    assign final_word = (remaining_q == LOG_MAX_WORDS'(1));
    assign completing = (lane_idx_q == LaneW'(LANES - 1)) || final_word;
    assign out_free   = !out_vld_q || rdy_i;
    assign step       = running && buf_vld && (!cur_bit || nz_vld_i) && (!completing || out_free);

    assign num_words_rdy_o = (state_q == IDLE) && !rst_i;
    assign mask_rdy_o      = running && !buf_vld;
    assign mask_load       = mask_rdy_o && mask_vld_i;
    assign nz_rdy_o        = step && cur_bit;
    assign idle_o          = (state_q == IDLE) && !out_vld_q && !rst_i;

    assign word   = cur_bit ? nz_i : '0;
    assign data_o = out_data_q;
    assign strb_o = out_strb_q;
    assign last_o = out_last_q;
    assign vld_o  = out_vld_q;

    ebpc_mask_buf #(
        .MASK_W (MASK_W)
    ) u_mask_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .mask_i    (mask_i),
        .load_i    (mask_load),
        .step_i    (step),
        .flush_i   (final_word),
        .cur_bit_o (cur_bit),
        .vld_o     (buf_vld)
    );

    // Assembly contents with the current word placed, and the strobe it would carry.
    always_comb begin
        asm_wr = asm_q;
        asm_wr[int'(lane_idx_q) * DATA_W +: DATA_W] = word;
        strb_wr = '0;
        for (int i = 0; i < LANES; i++) begin
            strb_wr[i] = (i <= int'(lane_idx_q));
        end
    end

    // Block framing: accept a count in IDLE, count words down in RUN.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                // A zero-length block is consumed without leaving IDLE.
                if (num_words_rdy_o && num_words_vld_i && (num_words_i != '0)) begin
                    state_d     = RUN;
                    remaining_d = num_words_i;
                end
            end
            RUN: begin
                if (step) begin
                    remaining_d = remaining_q - 1'b1;
                    if (final_word) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane assembly and output register; a completing step refills the output in place.
    always_comb begin
        lane_idx_d = lane_idx_q;
        asm_d      = asm_q;
        out_data_d = out_data_q;
        out_strb_d = out_strb_q;
        out_last_d = out_last_q;
        out_vld_d  = out_vld_q;
        if (out_vld_q && rdy_i) begin
            out_vld_d = 1'b0;
        end
        if (step) begin
            if (completing) begin
                out_data_d = asm_wr;
                out_strb_d = strb_wr;
                out_last_d = final_word;
                out_vld_d  = 1'b1;
                asm_d      = '0;
                lane_idx_d = '0;
            end else begin
                asm_d      = asm_wr;
                lane_idx_d = lane_idx_q + 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            lane_idx_q  <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            lane_idx_q  <= lane_idx_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
            out_vld_q   <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_ebpc_znz_expander.sv
// Directed self-checking bench for ebpc_znz_expander (LANES=4, MASK_W=8, DATA_W=8).
module tb_ebpc_znz_expander;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [7:0]  num_words_i;
    logic        num_words_vld_i;
    logic        num_words_rdy_o;
    logic [7:0]  mask_i;
    logic        mask_vld_i;
    logic        mask_rdy_o;
    logic [7:0]  nz_i;
    logic        nz_vld_i;
    logic        nz_rdy_o;
    logic [31:0] data_o;
    logic [3:0]  strb_o;
    logic        last_o;
    logic        vld_o;
    logic        rdy_i;
    logic        idle_o;

    logic [7:0] nw_fifo[$];
    logic [7:0] mask_fifo[$];
    logic [7:0] nz_fifo[$];
    beat_t      rcv[$];
    logic       rdy_en;
    int         nw_cnt = 0;
    int         mask_cnt = 0;
    int         nz_cnt = 0;
    int         vld_cycles = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ebpc_znz_expander #(
        .DATA_W        (8),
        .LANES         (4),
        .MASK_W        (8),
        .LOG_MAX_WORDS (8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .num_words_i     (num_words_i),
        .num_words_vld_i (num_words_vld_i),
        .num_words_rdy_o (num_words_rdy_o),
        .mask_i          (mask_i),
        .mask_vld_i      (mask_vld_i),
        .mask_rdy_o      (mask_rdy_o),
        .nz_i            (nz_i),
        .nz_vld_i        (nz_vld_i),
        .nz_rdy_o        (nz_rdy_o),
        .data_o          (data_o),
        .strb_o          (strb_o),
        .last_o          (last_o),
        .vld_o           (vld_o),
        .rdy_i           (rdy_i),
        .idle_o          (idle_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [31:0] d,
                              input logic [3:0] s, input logic l);
        if (rcv.size() > idx) begin
            check_val({tag, "_data"}, 64'(rcv[idx].d), 64'(d));
            check_val({tag, "_strb"}, 64'(rcv[idx].s), 64'(s));
            check_val({tag, "_last"}, 64'(rcv[idx].l), 64'(l));
        end else begin
            check_val({tag, "_missing"}, 64'(rcv.size()), 64'(idx + 1));
        end
    endtask

    // Wait until n beats arrived, all sources drained and the DUT is idle.
    task automatic wait_done(input string tag, input int n, input int budget);
        int k = 0;
        while ((rcv.size() < n || !idle_o || nw_fifo.size() != 0 || mask_fifo.size() != 0 ||
                nz_fifo.size() != 0) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= budget) check_val({tag, "_timeout"}, 64'(1), 64'(0));
    endtask

    // Source/sink driver: handshakes are decided at negedge, queues advanced after posedge.
    initial begin
        logic nw_hs, mask_hs, nz_hs;
        num_words_i     = '0;
        num_words_vld_i = 1'b0;
        mask_i          = '0;
        mask_vld_i      = 1'b0;
        nz_i            = '0;
        nz_vld_i        = 1'b0;
        rdy_i           = 1'b1;
        forever begin
            @(negedge clk);
            nw_hs   = !rst_i && num_words_vld_i && num_words_rdy_o;
            mask_hs = !rst_i && mask_vld_i && mask_rdy_o;
            nz_hs   = !rst_i && nz_vld_i && nz_rdy_o;
            if (!rst_i && vld_o) vld_cycles++;
            if (!rst_i && vld_o && rdy_i) rcv.push_back('{d: data_o, s: strb_o, l: last_o});
            @(posedge clk);
            #1;
            if (nw_hs) begin void'(nw_fifo.pop_front()); nw_cnt++; end
            if (mask_hs) begin void'(mask_fifo.pop_front()); mask_cnt++; end
            if (nz_hs) begin void'(nz_fifo.pop_front()); nz_cnt++; end
            num_words_vld_i = (nw_fifo.size() != 0);
            num_words_i     = (nw_fifo.size() != 0) ? nw_fifo[0] : 8'h00;
            mask_vld_i      = (mask_fifo.size() != 0);
            mask_i          = (mask_fifo.size() != 0) ? mask_fifo[0] : 8'h00;
            nz_vld_i        = (nz_fifo.size() != 0);
            nz_i            = (nz_fifo.size() != 0) ? nz_fifo[0] : 8'h00;
            rdy_i           = rdy_en;
        end
    end

    initial begin
        int    b_nw, b_mask, b_nz, b_vld, k, changes;
        logic [31:0] held;
        rst_i  = 1'b1;
        rdy_en = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_val("rst_vld", 64'(vld_o), 64'(0));
        check_val("rst_data", 64'(data_o), 64'(0));
        check_val("rst_strb", 64'(strb_o), 64'(0));
        check_val("rst_last", 64'(last_o), 64'(0));
        check_val("rst_nw_rdy", 64'(num_words_rdy_o), 64'(0));
        check_val("rst_mask_rdy", 64'(mask_rdy_o), 64'(0));
        check_val("rst_nz_rdy", 64'(nz_rdy_o), 64'(0));
        check_val("rst_idle", 64'(idle_o), 64'(0));
        @(posedge clk); #2;
        rst_i = 1'b0;
        @(negedge clk); #1;
        check_val("post_rst_nw_rdy", 64'(num_words_rdy_o), 64'(1));
        check_val("post_rst_idle", 64'(idle_o), 64'(1));

        // Test 1: N=5, mask 0x16.
        @(posedge clk); #2;
        nw_fifo.push_back(8'd5);
        mask_fifo.push_back(8'h16);
        nz_fifo = '{8'h11, 8'h22, 8'h33};
        wait_done("t1", 2, 100);
        check_beat("t1_b0", 0, 32'h0022_1100, 4'b1111, 1'b0);
        check_beat("t1_b1", 1, 32'h0000_0033, 4'b0001, 1'b1);
        check_val("t1_nbeats", 64'(rcv.size()), 64'(2));
        rcv.delete();

        // Test 2: N=0 consumes only the count.
        b_nw = nw_cnt; b_mask = mask_cnt; b_nz = nz_cnt; b_vld = vld_cycles;
        @(posedge clk); #2;
        nw_fifo.push_back(8'd0);
        repeat (6) @(negedge clk);
        #1;
        check_val("t2_nw_hs", 64'(nw_cnt - b_nw), 64'(1));
        check_val("t2_mask_hs", 64'(mask_cnt - b_mask), 64'(0));
        check_val("t2_nz_hs", 64'(nz_cnt - b_nz), 64'(0));
        check_val("t2_vld", 64'(vld_cycles - b_vld), 64'(0));
        check_val("t2_nw_rdy", 64'(num_words_rdy_o), 64'(1));

        // Test 3: N=10 across two mask beats.
        b_mask = mask_cnt; b_nz = nz_cnt;
        @(posedge clk); #2;
        nw_fifo.push_back(8'd10);
        mask_fifo = '{8'hFF, 8'h03};
        for (int i = 1; i <= 10; i++) nz_fifo.push_back(8'(i));
        wait_done("t3", 3, 200);
        check_beat("t3_b0", 0, 32'h0403_0201, 4'b1111, 1'b0);
        check_beat("t3_b1", 1, 32'h0807_0605, 4'b1111, 1'b0);
        check_beat("t3_b2", 2, 32'h0000_0A09, 4'b0011, 1'b1);
        check_val("t3_mask_hs", 64'(mask_cnt - b_mask), 64'(2));
        check_val("t3_nz_hs", 64'(nz_cnt - b_nz), 64'(10));
        rcv.delete();

        // Test 4: N=16, output held off for 20 cycles after the first beat.
        b_nz = nz_cnt;
        @(posedge clk); #2;
        rdy_en = 1'b0;
        @(posedge clk); #2;
        nw_fifo.push_back(8'd16);
        mask_fifo = '{8'hFF, 8'hFF};
        for (int i = 1; i <= 16; i++) nz_fifo.push_back(8'(i));
        k = 0;
        while (!vld_o && k < 100) begin @(negedge clk); #1; k++; end
        if (k >= 100) check_val("t4_vld_timeout", 64'(1), 64'(0));
        held = data_o;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (data_o !== held || !vld_o) changes++;
        end
        check_val("t4_first", 64'(held), 64'h0403_0201);
        check_val("t4_stable", 64'(changes), 64'(0));
        check_val("t4_nz_rdy_stall", 64'(nz_rdy_o), 64'(0));
        check_val("t4_nz_hs_stall", 64'(nz_cnt - b_nz), 64'(7));
        @(posedge clk); #2;
        rdy_en = 1'b1;
        wait_done("t4", 4, 200);
        check_beat("t4_b0", 0, 32'h0403_0201, 4'b1111, 1'b0);
        check_beat("t4_b1", 1, 32'h0807_0605, 4'b1111, 1'b0);
        check_beat("t4_b2", 2, 32'h0C0B_0A09, 4'b1111, 1'b0);
        check_beat("t4_b3", 3, 32'h100F_0E0D, 4'b1111, 1'b1);
        rcv.delete();

        // Test 5: reset mid-block after three words, then a clean block.
        b_nz = nz_cnt;
        @(posedge clk); #2;
        nw_fifo.push_back(8'd8);
        mask_fifo.push_back(8'hFF);
        nz_fifo = '{8'h51, 8'h52, 8'h53};
        k = 0;
        while (nz_cnt - b_nz < 3 && k < 100) begin @(negedge clk); #1; k++; end
        if (k >= 100) check_val("t5_step_timeout", 64'(1), 64'(0));
        @(posedge clk); #2;
        rst_i = 1'b1;
        @(posedge clk); #2;
        rst_i = 1'b0;
        @(negedge clk); #1;
        check_val("t5_vld", 64'(vld_o), 64'(0));
        check_val("t5_data", 64'(data_o), 64'(0));
        check_val("t5_strb", 64'(strb_o), 64'(0));
        check_val("t5_last", 64'(last_o), 64'(0));
        check_val("t5_mask_rdy", 64'(mask_rdy_o), 64'(0));
        check_val("t5_nz_rdy", 64'(nz_rdy_o), 64'(0));
        check_val("t5_idle", 64'(idle_o), 64'(1));
        check_val("t5_nbeats_rst", 64'(rcv.size()), 64'(0));
        @(posedge clk); #2;
        nw_fifo.push_back(8'd4);
        mask_fifo.push_back(8'h0F);
        nz_fifo = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        wait_done("t5", 1, 100);
        check_beat("t5_b0", 0, 32'hA4A3_A2A1, 4'b1111, 1'b1);
        check_val("t5_nbeats", 64'(rcv.size()), 64'(1));
        rcv.delete();

        // Test 6: back-to-back blocks each start on a fresh mask beat.
        b_mask = mask_cnt;
        @(posedge clk); #2;
        nw_fifo = '{8'd3, 8'd3};
        mask_fifo = '{8'h07, 8'h00};
        nz_fifo = '{8'h01, 8'h02, 8'h03};
        wait_done("t6", 2, 100);
        check_beat("t6_b0", 0, 32'h0003_0201, 4'b0111, 1'b1);
        check_beat("t6_b1", 1, 32'h0000_0000, 4'b0111, 1'b1);
        check_val("t6_mask_hs", 64'(mask_cnt - b_mask), 64'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
